hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: forwarding selects, load-use
// stalls, multi-cycle redirect flushes, dmem-wait freezes and saturating event counters.
module hazard_ctrl #(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned IMEM_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [RA_W-1:0]  ex_rs1,
    input  logic [RA_W-1:0]  ex_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_is_load,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             freeze,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned   FC_W    = 3;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(IMEM_LAT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [FC_W-1:0] fcnt_q, fcnt_n;

    logic load_use, mem_wait, flushing;
    logic stall_if_c, stall_id_c, bubble_ex_c, flush_id_c, freeze_c, stall_evt_c;
    logic [1:0] fwd1_c, fwd2_c;

    // Hazard conditions; a non-zero flush count means the wrong-path window is still open
    always_comb begin
        load_use = ex_is_load & ex_reg_write & (ex_rd != '0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
        mem_wait = (state_q == WAIT) ? ~mem_ready : (mem_req & ~mem_ready);
        flushing = (fcnt_q != '0);
    end

    // State register and flush counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_n;
            fcnt_q  <= fcnt_n;
        end
    end

    // Next state and control outputs; dmem wait > redirect > flush window > load-use
    always_comb begin
        state_n     = state_q;
        fcnt_n      = fcnt_q;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        bubble_ex_c = 1'b0;
        flush_id_c  = 1'b0;
        freeze_c    = 1'b0;
        stall_evt_c = 1'b0;
        if (mem_wait) begin
            freeze_c   = 1'b1;
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            state_n    = WAIT;
        end else if (ex_redirect) begin
            flush_id_c  = 1'b1;
            bubble_ex_c = 1'b1;
            fcnt_n      = FC_LOAD;
            state_n     = (IMEM_LAT != 0) ? FLUSH : RUN;
        end else if (flushing) begin
            flush_id_c = 1'b1;
            fcnt_n     = fcnt_q - FC_W'(1);
            state_n    = (fcnt_q == FC_W'(1)) ? RUN : FLUSH;
        end else begin
            state_n = RUN;
            if (load_use) begin
                stall_if_c  = 1'b1;
                stall_id_c  = 1'b1;
                bubble_ex_c = 1'b1;
                stall_evt_c = 1'b1;
            end
        end
    end

    // MEM result beats WB data; x0 is never forwarded and loads in MEM are not forwardable
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic            mem_ok,
                                           input logic [RA_W-1:0] mrd,
                                           input logic            wb_ok,
                                           input logic [RA_W-1:0] wrd);
        if (mem_ok && (mrd != '0) && (mrd == rs))
            return 2'd1;
        else if (wb_ok && (wrd != '0) && (wrd == rs))
            return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        fwd1_c = fwd_sel(ex_rs1, mem_reg_write & ~mem_is_load, mem_rd, wb_reg_write, wb_rd);
        fwd2_c = fwd_sel(ex_rs2, mem_reg_write & ~mem_is_load, mem_rd, wb_reg_write, wb_rd);
    end

    // Controls are combinational from the current cycle; reset forces them low at once
    assign stall_if    = stall_if_c  & rst_n;
    assign stall_id    = stall_id_c  & rst_n;
    assign bubble_ex   = bubble_ex_c & rst_n;
    assign flush_id    = flush_id_c  & rst_n;
    assign freeze      = freeze_c    & rst_n;
    assign fwd_rs1_sel = fwd1_c & {2{rst_n}};
    assign fwd_rs2_sel = fwd2_c & {2{rst_n}};

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_evt_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_id_c  && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (freeze_c    && (wait_cnt  != '1)) wait_cnt  <= wait_cnt  + CNT_W'(1);
        end
    end

    // A load still in MEM feeding EX means the load-use stall was missed upstream
    a_no_load_fwd_rs1: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_is_load && (mem_rd != '0) && (mem_rd == ex_rs1)));
    a_no_load_fwd_rs2: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_is_load && (mem_rd != '0) && (mem_rd == ex_rs2)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (IMEM_LAT=2, CNT_W=4) with hand-computed expectations.
module tb_hazard_ctrl;

    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_reg_write, ex_is_load;
    logic mem_reg_write, mem_is_load, wb_reg_write, ex_redirect, mem_req, mem_ready;
    logic stall_if, stall_id, bubble_ex, flush_id, freeze;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    hazard_ctrl #(.RA_W(RA_W), .IMEM_LAT(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .freeze(freeze),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; mem_is_load = 1'b0;
        wb_rd = '0; wb_reg_write = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall_if"},  32'(stall_if),    0);
        check({tag, ".stall_id"},  32'(stall_id),    0);
        check({tag, ".bubble_ex"}, 32'(bubble_ex),   0);
        check({tag, ".flush_id"},  32'(flush_id),    0);
        check({tag, ".freeze"},    32'(freeze),      0);
        check({tag, ".fwd1"},      32'(fwd_rs1_sel), 0);
        check({tag, ".fwd2"},      32'(fwd_rs2_sel), 0);
        check({tag, ".stall_cnt"}, 32'(stall_cnt),   0);
        check({tag, ".flush_cnt"}, 32'(flush_cnt),   0);
        check({tag, ".wait_cnt"},  32'(wait_cnt),    0);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // lw x5 in EX, add x6,x5,x1 in ID
        next(); clr(); set_load_use(); id_rs2 = 5'd1; id_uses_rs2 = 1'b1; #1;
        check("lu.stall_if",  32'(stall_if),  1);
        check("lu.stall_id",  32'(stall_id),  1);
        check("lu.bubble_ex", 32'(bubble_ex), 1);
        check("lu.flush_id",  32'(flush_id),  0);
        check("lu.freeze",    32'(freeze),    0);
        next(); clr(); mem_rd = 5'd5; mem_reg_write = 1'b1; mem_is_load = 1'b1;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1; #1;
        check("lu2.stall_if",  32'(stall_if),  0);
        check("lu2.stall_cnt", 32'(stall_cnt), 1);
        next(); clr(); wb_rd = 5'd5; wb_reg_write = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd1; #1;
        check("lu3.fwd1",      32'(fwd_rs1_sel), 2);
        check("lu3.fwd2",      32'(fwd_rs2_sel), 0);
        check("lu3.stall_cnt", 32'(stall_cnt),   1);

        // x0 never stalls or forwards
        next(); clr(); ex_is_load = 1'b1; ex_reg_write = 1'b1; id_uses_rs1 = 1'b1;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1; #1;
        check("x0.stall_if",  32'(stall_if),    0);
        check("x0.bubble_ex", 32'(bubble_ex),   0);
        check("x0.fwd1",      32'(fwd_rs1_sel), 0);

        // MEM beats WB
        next(); clr(); mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd7; wb_reg_write = 1'b1;
        ex_rs2 = 5'd7; ex_rs1 = 5'd3; #1;
        check("prio.fwd2", 32'(fwd_rs2_sel), 1);
        check("prio.fwd1", 32'(fwd_rs1_sel), 0);

        // single redirect: 3 flush cycles, bubble only in the first
        next(); clr(); ex_redirect = 1'b1; #1;
        check("fl1.flush_id",  32'(flush_id),  1);
        check("fl1.bubble_ex", 32'(bubble_ex), 1);
        check("fl1.stall_if",  32'(stall_if),  0);
        check("fl1.stall_id",  32'(stall_id),  0);
        next(); clr(); set_load_use(); #1;
        check("fl2.flush_id",  32'(flush_id),  1);
        check("fl2.bubble_ex", 32'(bubble_ex), 0);
        check("fl2.stall_if",  32'(stall_if),  0);
        next(); clr(); #1;
        check("fl3.flush_id", 32'(flush_id), 1);
        next(); #1;
        check("fl4.flush_id",  32'(flush_id),  0);
        check("fl4.flush_cnt", 32'(flush_cnt), 3);
        check("fl4.stall_cnt", 32'(stall_cnt), 1);

        // second redirect in cycle 2 extends the flush to cycle 4
        next(); ex_redirect = 1'b1; #1;
        check("rf1.flush_id", 32'(flush_id), 1);
        next(); #1;
        check("rf2.flush_id", 32'(flush_id), 1);
        next(); clr(); #1;
        check("rf3.flush_id", 32'(flush_id), 1);
        next(); #1;
        check("rf4.flush_id", 32'(flush_id), 1);
        next(); #1;
        check("rf5.flush_id",  32'(flush_id),  0);
        check("rf5.flush_cnt", 32'(flush_cnt), 7);

        // dmem wait of 3 cycles with a held redirect serviced on release
        next(); clr(); mem_req = 1'b1; ex_redirect = 1'b1; #1;
        check("w1.freeze",    32'(freeze),    1);
        check("w1.stall_if",  32'(stall_if),  1);
        check("w1.stall_id",  32'(stall_id),  1);
        check("w1.flush_id",  32'(flush_id),  0);
        check("w1.bubble_ex", 32'(bubble_ex), 0);
        next(); #1;
        check("w2.freeze", 32'(freeze), 1);
        next(); #1;
        check("w3.freeze", 32'(freeze), 1);
        next(); mem_ready = 1'b1; #1;
        check("w4.freeze",    32'(freeze),    0);
        check("w4.stall_if",  32'(stall_if),  0);
        check("w4.flush_id",  32'(flush_id),  1);
        check("w4.bubble_ex", 32'(bubble_ex), 1);
        check("w4.wait_cnt",  32'(wait_cnt),  3);
        next(); clr(); #1;
        check("w5.flush_id", 32'(flush_id), 1);
        check("w5.wait_cnt", 32'(wait_cnt), 3);
        next(); #1;
        check("w6.flush_id", 32'(flush_id), 1);
        next(); #1;
        check("w7.flush_id",  32'(flush_id),  0);
        check("w7.flush_cnt", 32'(flush_cnt), 10);

        // dmem wait inside a flush window pauses the flush count
        next(); ex_redirect = 1'b1; #1;
        check("p1.flush_id", 32'(flush_id), 1);
        next(); clr(); mem_req = 1'b1; #1;
        check("p2.freeze",   32'(freeze),   1);
        check("p2.flush_id", 32'(flush_id), 0);
        next(); mem_ready = 1'b1; #1;
        check("p3.freeze",   32'(freeze),   0);
        check("p3.flush_id", 32'(flush_id), 1);
        next(); clr(); #1;
        check("p4.flush_id", 32'(flush_id), 1);
        next(); #1;
        check("p5.flush_id",  32'(flush_id),  0);
        check("p5.flush_cnt", 32'(flush_cnt), 13);
        check("p5.wait_cnt",  32'(wait_cnt),  4);

        // redirect beats load-use in the same cycle
        next(); clr(); set_load_use(); ex_redirect = 1'b1; #1;
        check("rl.flush_id",  32'(flush_id),  1);
        check("rl.bubble_ex", 32'(bubble_ex), 1);
        check("rl.stall_if",  32'(stall_if),  0);
        check("rl.stall_id",  32'(stall_id),  0);
        next(); clr(); #1;
        check("rl2.stall_cnt", 32'(stall_cnt), 1);
        check("rl2.flush_id",  32'(flush_id),  1);

        // asynchronous reset mid-flush with hazards still asserted
        set_load_use(); ex_redirect = 1'b1; mem_req = 1'b1;
        mem_rd = 5'd9; mem_reg_write = 1'b1; ex_rs1 = 5'd9;
        rst_n = 1'b0; #1;
        check_all_zero("rst_mid");
        next(); rst_n = 1'b1; clr(); #1;
        check("rel.flush_id",  32'(flush_id),  0);
        check("rel.freeze",    32'(freeze),    0);
        check("rel.flush_cnt", 32'(flush_cnt), 0);

        // 20 load-use cycles saturate the 4-bit stall counter
        next(); set_load_use(); #1;
        repeat (20) next();
        check("sat.stall_if",  32'(stall_if),  1);
        check("sat.stall_cnt", 32'(stall_cnt), 15);

        clr();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
